// File: rtl/common_fifo_1w2r_dffram_pkg.sv
// Shared helpers for the one-write/two-read FIFO.
package common_fifo_1w2r_dffram_pkg;

  localparam int MAX_POPS = 2;

  // A request of 3 saturates to the two read ports available.
  function automatic logic [1:0] clamp_pop(input logic [1:0] req);
    return req[1] ? 2'd2 : req;
  endfunction

endpackage

// File: rtl/common_fifo_1w2r_dffram_ram.sv
// Flop-based storage: one write port (A), two asynchronous read ports (B, C).
module common_dffram_3a1w2r #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_we,
  input  logic [AW-1:0]         a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [AW-1:0]         b_addr,
  output logic [DATA_WIDTH-1:0] b_rdata,
  input  logic [AW-1:0]         c_addr,
  output logic [DATA_WIDTH-1:0] c_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (a_we) mem_d[a_addr] = a_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign b_rdata = mem_q[b_addr];
  assign c_rdata = mem_q[c_addr];

endmodule

// File: rtl/common_fifo_1w2r_dffram.sv
// FIFO with a single push port and up to two pops per cycle; zero-latency reads.
module common_fifo_1w2r_dffram
  import common_fifo_1w2r_dffram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic [1:0]                   pop_req,
  output logic                         pop0_valid,
  output logic [DATA_WIDTH-1:0]        pop0_data,
  output logic                         pop1_valid,
  output logic [DATA_WIDTH-1:0]        pop1_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         err_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d, req_c, npop;
  logic          err_q, err_d, push_acc;

  always_comb begin
    req_c    = CW'(clamp_pop(pop_req));
    npop     = (req_c > count_q) ? count_q : req_c;
    // Full blocks pushes regardless of a same-cycle pop.
    push_acc = push_valid && (count_q != CW'(DEPTH));
    count_d  = count_q + CW'(push_acc) - npop;
    wptr_d   = wptr_q + AW'(push_acc);
    // DEPTH is a power of two, so truncation gives the modulo wrap.
    rptr_d   = rptr_q + npop[AW-1:0];
    err_d    = err_q | (req_c > count_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  common_dffram_3a1w2r #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .a_we    (push_acc),
    .a_addr  (wptr_q),
    .a_wdata (push_data),
    .b_addr  (rptr_q),
    .b_rdata (pop0_data),
    .c_addr  (rptr_q + AW'(1)),
    .c_rdata (pop1_data)
  );

  assign count         = count_q;
  assign empty         = (count_q == '0);
  assign full          = (count_q == CW'(DEPTH));
  assign push_ready    = !full;
  assign pop0_valid    = (count_q != '0);
  assign pop1_valid    = (count_q >= CW'(2));
  assign err_underflow = err_q;

endmodule

// File: tb/tb_common_fifo_1w2r_dffram.sv
// Directed bench for the 1-write/2-read FIFO, with a queue reference model.
module tb_common_fifo_1w2r_dffram;

  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [DW-1:0] push_data = '0;
  logic [1:0]    pop_req = '0;
  logic          pop0_valid, pop1_valid;
  logic [DW-1:0] pop0_data, pop1_data;
  logic [2:0]    count;
  logic          empty, full, err_underflow;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mq[$];
  bit            m_err;

  always #5 clk = ~clk;

  common_fifo_1w2r_dffram #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_req(pop_req),
    .pop0_valid(pop0_valid), .pop0_data(pop0_data),
    .pop1_valid(pop1_valid), .pop1_data(pop1_data),
    .count(count), .empty(empty), .full(full), .err_underflow(err_underflow)
  );

  // Reference model: a plain queue updated from the FIFO rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      int req, n;
      bit acc;
      acc = push_valid && (mq.size() < DEPTH);
      req = (pop_req == 2'd3) ? 2 : int'(pop_req);
      n   = (req > mq.size()) ? mq.size() : req;
      if (req > mq.size()) m_err = 1'b1;
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      if (acc) mq.push_back(push_data);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int sz;
    sz = mq.size();
    chk("m_count", int'(count), sz);
    chk("m_empty", int'(empty), int'(sz == 0));
    chk("m_full", int'(full), int'(sz == DEPTH));
    chk("m_push_ready", int'(push_ready), int'(sz != DEPTH));
    chk("m_pop0_valid", int'(pop0_valid), int'(sz >= 1));
    chk("m_pop1_valid", int'(pop1_valid), int'(sz >= 2));
    chk("m_err", int'(err_underflow), int'(m_err));
    if (sz >= 1) chk("m_pop0_data", int'(pop0_data), int'(mq[0]));
    if (sz >= 2) chk("m_pop1_data", int'(pop1_data), int'(mq[1]));
  end

  task automatic cyc(input logic pv, input logic [DW-1:0] d, input logic [1:0] pr);
    push_valid = pv;
    push_data  = d;
    pop_req    = pr;
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    pop_req    = 2'd0;
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_push_ready", int'(push_ready), 1);
    chk("rst_pop0_valid", int'(pop0_valid), 0);
    chk("rst_pop0_data", int'(pop0_data), 8'h00);
    chk("rst_pop1_data", int'(pop1_data), 8'h00);
    reset = 1'b0;

    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0); cyc(1, 8'h44, 0);
    chk("fill_full", int'(full), 1);
    chk("fill_push_ready", int'(push_ready), 0);
    chk("fill_count", int'(count), 4);
    // Full: push refused even with a same-cycle pop request absent.
    cyc(1, 8'h55, 0);
    chk("fill5_count", int'(count), 4);
    chk("fill5_head", int'(pop0_data), 8'h11);

    cyc(0, 8'h00, 2);
    chk("dual_pop0", int'(pop0_data), 8'h33);
    chk("dual_pop1", int'(pop1_data), 8'h44);
    chk("dual_count", int'(count), 2);

    cyc(1, 8'h77, 1);
    chk("pp_count", int'(count), 2);
    chk("pp_pop0", int'(pop0_data), 8'h44);
    chk("pp_pop1", int'(pop1_data), 8'h77);

    // Drain, then move both pointers to 3 for the wrap case.
    cyc(0, 8'h00, 2);
    chk("drain_empty", int'(empty), 1);
    cyc(1, 8'h01, 0); cyc(1, 8'h02, 0); cyc(0, 8'h00, 2);
    chk("pos_count", int'(count), 0);

    cyc(1, 8'hA0, 0); cyc(1, 8'hA1, 0); cyc(1, 8'hA2, 0);
    chk("wrap_pop0", int'(pop0_data), 8'hA0);
    chk("wrap_pop1", int'(pop1_data), 8'hA1);
    cyc(0, 8'h00, 2);
    chk("wrap_head", int'(pop0_data), 8'hA2);
    chk("wrap_count", int'(count), 1);

    chk("uf_before", int'(err_underflow), 0);
    cyc(0, 8'h00, 2);
    chk("uf_count", int'(count), 0);
    chk("uf_err", int'(err_underflow), 1);
    cyc(1, 8'hB0, 0); cyc(0, 8'h00, 1);
    chk("uf_sticky", int'(err_underflow), 1);

    // Mixed interleaving including pop_req=3; the model checks each cycle.
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)));

    // Asynchronous reset mid-operation.
    cyc(1, 8'hC1, 0); cyc(1, 8'hC2, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_err", int'(err_underflow), 0);
    chk("arst_pop0_data", int'(pop0_data), 8'h00);
    chk("arst_pop1_data", int'(pop1_data), 8'h00);
    @(posedge clk); #1;
    cyc(1, 8'h99, 0);
    chk("rsthi_count", int'(count), 0);
    chk("rsthi_data", int'(pop0_data), 8'h00);
    reset = 1'b0;
    cyc(1, 8'h5A, 0);
    chk("post_rst_head", int'(pop0_data), 8'h5A);
    chk("post_rst_count", int'(count), 1);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/common_fifo_1w2r_dffram.md
COMMON_FIFO_1W2R_DFFRAM -- requirements
Module: common_fifo_1w2r_dffram

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL take parameter DATA_WIDTH, default 8, meaning entry width in bits.
REQ-003 SHALL take parameter DEPTH, default 8, meaning entry count; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  async active-high reset.
REQ-006 SHALL have port push_valid  input  1  producer offers push_data.
REQ-007 SHALL have port push_ready  output  1  FIFO can accept; equals !full.
REQ-008 SHALL have port push_data  input  DATA_WIDTH  entry to enqueue.
REQ-009 SHALL have port pop_req  input  2  entries to dequeue this cycle (0, 1, 2; 3 treated as 2).
REQ-010 SHALL have port pop0_valid / pop0_data  output  1 / DATA_WIDTH  head entry present / value.
REQ-011 SHALL have port pop1_valid / pop1_data  output  1 / DATA_WIDTH  head+1 entry present / value.
REQ-012 SHALL have port count  output  clog2(DEPTH+1)  current occupancy.
REQ-013 SHALL have ports empty, full  output  1 each  count==0, count==DEPTH.
REQ-014 SHALL have port err_underflow  output  1  sticky: a pop exceeded occupancy.

Function
REQ-015 SHALL accept a push when push_valid & push_ready at a rising clk edge; data written at wptr, wptr increments modulo DEPTH.
REQ-016 SHALL compute effective pops npop = min(pop_req clamped to 2, count) from registered count; rptr advances by npop modulo DEPTH.
REQ-017 SHALL set err_underflow at the edge where clamped pop_req > count; it stays set until reset.
REQ-018 SHALL update count = count + push_accepted - npop each edge; all arithmetic at clog2(DEPTH+1) bits, never wrapping.
REQ-019 SHALL present pop0_data = entry[rptr], pop1_data = entry[(rptr+1) mod DEPTH] combinationally from storage (zero read latency).
REQ-020 SHALL drive pop0_valid = (count>=1), pop1_valid = (count>=2); data on an invalid port is don't-care but deterministic storage contents.
REQ-021 SHALL, when full, deassert push_ready even if a pop occurs the same cycle (no full-bypass).
REQ-022 SHALL, when empty, not bypass push_data to pop0_data; a pushed entry becomes visible the cycle after acceptance.
REQ-023 SHALL support simultaneous push and 1- or 2-pop in one cycle, including when wptr and rptr wrap in the same cycle.
REQ-024 SHALL preserve FIFO order across wrap-around for any interleaving of pushes and pops.

Reset
REQ-025 SHALL on reset assertion immediately set wptr=0, rptr=0, count=0, empty=1, full=0, push_ready=1, pop0_valid=0, pop1_valid=0, err_underflow=0.
REQ-026 SHALL reset all storage entries to zero, so pop0_data=pop1_data=0 during and after reset.
REQ-027 SHALL, on reset mid-operation, discard all stored entries; no push or pop is accepted while reset is high.

Structure
REQ-028 SHALL keep pointer and count widths as local constants; no shared package or typedefs are required.
REQ-029 SHALL instantiate exactly one storage sub-module, common_dffram_3a1w2r (port A = push write, port B = rptr read, port C = rptr+1 read, binary addressing, no bit-write-enable).
REQ-030 SHALL keep pointer, count and error-flag logic in this module as a flat register set (no further sub-modules).

Verification (DATA_WIDTH=8, DEPTH=4)
REQ-031 SHALL verify reset: after reset, count=0, empty=1, push_ready=1, pop0_valid=0, pop0_data=0x00.
REQ-032 SHALL verify fill: push 0x11,0x22,0x33,0x44 -> full=1, push_ready=0, count=4; 5th push 0x55 not accepted.
REQ-033 SHALL verify dual pop: from 0x11..0x44, pop_req=2 -> next cycle pop0_data=0x33, pop1_data=0x44, count=2.
REQ-034 SHALL verify wrap: with rptr=3, wptr=3, count=0, push 0xA0,0xA1,0xA2 then pop_req=2 -> pops 0xA0,0xA1 in order, then pop0_data=0xA2, count=1.
REQ-035 SHALL verify underflow: count=1, pop_req=2 -> one entry removed, count=0, err_underflow=1 held until reset.
REQ-036 SHALL verify simultaneous push+pop: count=2, push 0x77 with pop_req=1 -> count stays 2, order preserved.
